// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Defaults describe 640x480@60 Hz with a 4:1 system-to-pixel clock ratio.
package vga_pkg;

    // Width of the pixel_x / pixel_y coordinates and of the pixel-period divider
    localparam int unsigned COORD_W = 10;
    localparam int unsigned TICK_W  = 4;

    // Default clock divide ratio (100 MHz system clock -> 25 MHz pixel rate)
    localparam int unsigned CLK_DIV_DEF = 4;

    // Default horizontal timing, in pixels
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    // Default vertical timing, in lines
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Default sync windows (inclusive): hsync low 656..751, vsync low 490..491
    localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    // Raster run state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vga_state_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-period divider: counts 0..CLK_DIV-1 and flags the last clock of each
// pixel. A synchronous clear holds the count at 0 while the raster is idle.
module pixel_tick_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic pixel_tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(CLK_DIV - 1);

    logic [TICK_W-1:0] div_reg;

    // Divider count, wrapping on the last clock of the pixel period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg <= '0;
        end else if (clear || (div_reg == LAST)) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign pixel_tick = (div_reg == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: run/idle FSM, horizontal and vertical pixel
// counters, registered visible-area and sync decode, plus one extra sync stage
// so hsync/vsync line up with the colorizer's registered RGB.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               pixel_tick,
    output logic               frame_start
);

    // Raster geometry expressed at coordinate width for width-clean compares
    localparam logic [COORD_W-1:0] H_ACT_C   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] H_LAST_C  = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [COORD_W-1:0] H_SYNC_S  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_E  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] V_ACT_C   = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] V_LAST_C  = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [COORD_W-1:0] V_SYNC_S  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_E  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    vga_state_t         state_reg, state_next;
    logic [COORD_W-1:0] x_reg, x_next;
    logic [COORD_W-1:0] y_reg, y_next;
    logic               video_on_reg, video_on_next;
    logic               frame_start_reg, frame_start_next;
    logic               hsync_pre_reg, hsync_pre_next;
    logic               vsync_pre_reg, vsync_pre_next;
    logic               hsync_reg, vsync_reg;
    logic               tick;
    logic               tick_clear;

    // The divider only runs while the raster is running and stays enabled
    assign tick_clear = (state_reg != ST_RUN) || !enable;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .clear      (tick_clear),
        .pixel_tick (tick)
    );

    // State, counter and decode registers; decode is taken from the next
    // counter values so it never lags pixel_x/pixel_y
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            x_reg           <= '0;
            y_reg           <= '0;
            video_on_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            hsync_pre_reg   <= 1'b1;
            vsync_pre_reg   <= 1'b1;
        end else begin
            state_reg       <= state_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            video_on_reg    <= video_on_next;
            frame_start_reg <= frame_start_next;
            hsync_pre_reg   <= hsync_pre_next;
            vsync_pre_reg   <= vsync_pre_next;
        end
    end

    // Extra sync stage matching the colorizer's RGB output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else begin
            hsync_reg <= hsync_pre_reg;
            vsync_reg <= vsync_pre_reg;
        end
    end

    // Next-state, counter advance and visible/sync decode; enable low wins
    // over any tick or wrap in the same clock
    always_comb begin
        state_next       = state_reg;
        x_next           = x_reg;
        y_next           = y_reg;
        frame_start_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                x_next = '0;
                y_next = '0;
                if (enable) begin
                    state_next       = ST_RUN;
                    frame_start_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    x_next     = '0;
                    y_next     = '0;
                end else if (tick) begin
                    if (x_reg == H_LAST_C) begin
                        x_next = '0;
                        if (y_reg == V_LAST_C) begin
                            y_next           = '0;
                            frame_start_next = 1'b1;
                        end else begin
                            y_next = y_reg + 1'b1;
                        end
                    end else begin
                        x_next = x_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                x_next     = '0;
                y_next     = '0;
            end
        endcase

        video_on_next  = (state_next == ST_RUN) && (x_next < H_ACT_C) && (y_next < V_ACT_C);
        hsync_pre_next = !((state_next == ST_RUN) && (x_next >= H_SYNC_S) && (x_next <= H_SYNC_E));
        vsync_pre_next = !((state_next == ST_RUN) && (y_next >= V_SYNC_S) && (y_next <= V_SYNC_E));
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = video_on_reg;
    assign pixel_x     = x_reg;
    assign pixel_y     = y_reg;
    assign pixel_tick  = tick && (state_reg == ST_RUN);
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 640x480 instance for reset,
// start-up, line timing, enable drop and mid-frame reset, plus a shrunken
// raster instance so frame wrap and vertical blanking fit in a short run.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       s_enable;

    logic       hsync, vsync, video_on, pixel_tick, frame_start;
    logic [9:0] pixel_x, pixel_y;
    logic       s_hsync, s_vsync, s_video_on, s_pixel_tick, s_frame_start;
    logic [9:0] s_pixel_x, s_pixel_y;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_tick  (pixel_tick),
        .frame_start (frame_start)
    );

    // Small raster: 15 x 8 pixels, 2 clocks/pixel, hsync x 10..12, vsync y 5..6
    vga_sync_gen #(
        .CLK_DIV (2),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_small (
        .clk         (clk),
        .reset       (reset),
        .enable      (s_enable),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .video_on    (s_video_on),
        .pixel_x     (s_pixel_x),
        .pixel_y     (s_pixel_y),
        .pixel_tick  (s_pixel_tick),
        .frame_start (s_frame_start)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic wait_xy(input int x, input int y, input int budget, input string tag);
        int n = 0;
        while (!(pixel_x == 10'(x) && pixel_y == 10'(y)) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(pixel_x == 10'(x) && pixel_y == 10'(y)), 32'd1);
    endtask

    initial begin
        int vo_cnt, hs_cnt, x_first, h_first;
        int fs_cnt, fs_second, vs_cnt, y_first, v_first, blank_bad, svo_cnt;

        reset    = 1'b1;
        enable   = 1'b0;
        s_enable = 1'b0;
        step(2);
        check("rst_video_on", 32'(video_on), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_x", 32'(pixel_x), 0);
        check("rst_y", 32'(pixel_y), 0);
        check("rst_tick", 32'(pixel_tick), 0);
        check("rst_fs", 32'(frame_start), 0);

        reset = 1'b0;
        step(3);
        check("idle_video_on", 32'(video_on), 0);
        check("idle_fs", 32'(frame_start), 0);

        // Start-up: entry clock loads (0,0), tick on 4th clock, x=1 on 5th
        enable = 1'b1;
        step();
        check("start_fs", 32'(frame_start), 1);
        check("start_video_on", 32'(video_on), 1);
        check("start_x", 32'(pixel_x), 0);
        check("start_y", 32'(pixel_y), 0);
        check("start_tick", 32'(pixel_tick), 0);
        step();
        check("clk2_fs", 32'(frame_start), 0);
        step(2);
        check("clk4_tick", 32'(pixel_tick), 1);
        check("clk4_x", 32'(pixel_x), 0);
        step();
        check("clk5_x", 32'(pixel_x), 1);
        check("clk5_tick", 32'(pixel_tick), 0);

        // One full line (line 1): video_on / hsync widths and hsync alignment
        wait_xy(0, 1, 4000, "reach_line1");
        vo_cnt = 0; hs_cnt = 0; x_first = -1; h_first = -1;
        for (int i = 0; i < 3200; i++) begin
            if (video_on) vo_cnt++;
            if (!hsync) hs_cnt++;
            if (x_first < 0 && pixel_x == 10'd656) x_first = i;
            if (h_first < 0 && !hsync) h_first = i;
            step();
        end
        check("line_video_on_clks", 32'(vo_cnt), 2560);
        check("line_hsync_low_clks", 32'(hs_cnt), 384);
        check("line_x656_clk", 32'(x_first), 2624);
        check("line_hsync_lag", 32'(h_first - x_first), 1);
        check("line_end_x", 32'(pixel_x), 0);
        check("line_end_y", 32'(pixel_y), 2);

        // Enable drop inside hsync at (700,10)
        wait_xy(700, 10, 40000, "reach_700_10");
        check("drop_hsync_before", 32'(hsync), 0);
        enable = 1'b0;
        step();
        check("drop_x", 32'(pixel_x), 0);
        check("drop_y", 32'(pixel_y), 0);
        check("drop_video_on", 32'(video_on), 0);
        check("drop_hsync_lag", 32'(hsync), 0);
        step();
        check("drop_hsync_after", 32'(hsync), 1);
        check("drop_tick", 32'(pixel_tick), 0);
        check("drop_fs", 32'(frame_start), 0);
        enable = 1'b1;
        step();
        check("reen_fs", 32'(frame_start), 1);
        check("reen_x", 32'(pixel_x), 0);
        check("reen_video_on", 32'(video_on), 1);

        // Asynchronous reset mid-line in the visible area
        wait_xy(300, 2, 10000, "reach_300_2");
        #2 reset = 1'b1;
        #1;
        check("areset_video_on", 32'(video_on), 0);
        check("areset_x", 32'(pixel_x), 0);
        check("areset_y", 32'(pixel_y), 0);
        reset = 1'b0;
        step();
        check("areset_restart_fs", 32'(frame_start), 1);

        // Asynchronous reset inside hsync returns the delayed sync at once
        wait_xy(700, 0, 4000, "reach_700_0");
        check("areset2_hsync_before", 32'(hsync), 0);
        #2 reset = 1'b1;
        enable = 1'b0;
        #1;
        check("areset2_hsync", 32'(hsync), 1);
        step();
        reset = 1'b0;
        step(2);
        check("post_reset_idle_x", 32'(pixel_x), 0);
        check("post_reset_idle_video_on", 32'(video_on), 0);
        check("post_reset_idle_fs", 32'(frame_start), 0);
        enable = 1'b1;
        step();
        check("post_reset_start_fs", 32'(frame_start), 1);

        // Small raster: two frames of 240 clocks each
        s_enable = 1'b1;
        step();
        fs_cnt = 0; fs_second = -1; vs_cnt = 0; y_first = -1; v_first = -1;
        blank_bad = 0; svo_cnt = 0;
        for (int i = 0; i < 480; i++) begin
            if (s_frame_start) begin
                fs_cnt++;
                if (i > 0 && fs_second < 0) begin
                    fs_second = i;
                    check("wrap_x", 32'(s_pixel_x), 0);
                    check("wrap_y", 32'(s_pixel_y), 0);
                end
            end
            if (i < 240) begin
                if (!s_vsync) vs_cnt++;
                if (s_video_on) svo_cnt++;
                if (y_first < 0 && s_pixel_y == 10'd5) y_first = i;
                if (v_first < 0 && !s_vsync) v_first = i;
            end
            if (s_pixel_y >= 10'd4 && s_video_on) blank_bad++;
            step();
        end
        check("small_fs_count", 32'(fs_cnt), 2);
        check("small_fs_period", 32'(fs_second), 240);
        check("small_vsync_low_clks", 32'(vs_cnt), 60);
        check("small_y5_clk", 32'(y_first), 150);
        check("small_vsync_lag", 32'(v_first - y_first), 1);
        check("small_video_on_clks", 32'(svo_cnt), 64);
        check("small_vblank_video_on", 32'(blank_bad), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
